tile_colour_mapper: RTL and testbench
=====================================

Name: tile_colour_mapper

Overview:
Parametrised, pipelined successor to the category-to-RGB stage of the VGA path. It maps a per-pixel tile category to RGB through a run-time writable palette instead of a fixed case table. Each palette entry also carries a blink attribute, driven by a frame-counted blink phase. The block sits between the map/sprite category generator and the VGA DAC pins and blanks its output outside the active video area.

Parameters:
CAT_W, 4, category and palette address width
NUM_CAT, 16, palette entries implemented (≤ 2^CAT_W)
COLOR_W, 4, bits per colour channel
BLINK_FRAMES, 16, frame_tick pulses per blink half-period (≥1)

Ports:
clk  in  1  system/pixel clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (end of vsync)
video_on  in  1  high during active display area, aligned with category
category  in  CAT_W  tile category of current pixel
pal_we  in  1  palette write strobe
pal_addr  in  CAT_W  palette entry to write
pal_data  in  3*COLOR_W  {red,green,blue}, red in MSBs
pal_blink  in  1  blink attribute written with pal_data
red  out  COLOR_W  red channel
green  out  COLOR_W  green channel
blue  out  COLOR_W  blue channel
video_on_out  out  1  video_on delayed to match RGB
blink_phase  out  1  current blink phase (1 = blinking entries visible)

Behaviour:
- Reset (rst sampled high at a clk edge): red/green/blue = 0, video_on_out = 0, blink_phase = 1, blink counter = 0, all pipeline registers cleared.
- Reset palette contents: entry 0 = 0x000 (NONE), entry 1 = all-ones (WALL), entry 2 = all-ones (TANK), all others = 0. All blink bits = 0.
- Reset mid-operation discards in-flight pixels. Outputs read 0 until two valid cycles after rst deasserts.
- Pipeline latency is 2 cycles; throughput is one pixel per clock with no stall.
- Stage 1: register the palette entry {rgb, blink} indexed by category, plus video_on.
  - category ≥ NUM_CAT yields rgb = 0, blink = 0.
- Stage 2: choose the output colour, register red/green/blue and video_on_out.
  - video_on stage-1 copy = 0 → RGB = 0.
  - Else entry blink = 1 and blink_phase = 0 → RGB = palette entry 0, the current background.
  - Else → entry rgb.
- Palette write: when pal_we = 1 and pal_addr < NUM_CAT, the entry updates at the clk edge. pal_we with pal_addr ≥ NUM_CAT is ignored.
- Write/lookup collision: a lookup sampled in the same cycle as a write to the same entry returns the old value. Lookups sampled from the next cycle onward return the new value.
- A write to entry 0 while stage 2 substitutes background uses the entry-0 value as read in stage 2 (registered entry 0).
- Blink counter, range 0..BLINK_FRAMES-1, advances only on frame_tick.
  - On a frame_tick with counter = BLINK_FRAMES-1: counter wraps to 0 and blink_phase toggles.
  - Otherwise: counter increments.
  - BLINK_FRAMES = 1 toggles on every tick.
- A blink_phase toggle takes effect for pixels in stage 2 on the cycle after the toggling edge.
- frame_tick and pal_we are fully independent. Simultaneous frame_tick, pal_we and pixel traffic are all honoured in the same cycle.
- rst has priority over frame_tick and pal_we.

Test Plan:
1. Reset, then category sequence 0,1,2,3 with video_on = 1 → two cycles later RGB = 000, FFF, FFF, 000 (hex per channel), matching fixed-table behaviour.
2. Write entry 3 = 0xF00 (blink = 0) at cycle N, category = 3 presented at N and at N+1 → RGB 0x000 at N+2, 0xF00 at N+3.
3. Entry 2 blink = 1, entry 0 = 0x00F, BLINK_FRAMES = 2, category held at 2 → RGB FFF for 2 frame_ticks, then 00F for 2 ticks, then FFF; blink_phase toggles on every 2nd tick.
4. category = 1 with video_on toggling 1,0,1 → RGB FFF, 000, FFF with video_on_out 1,0,1, each two cycles delayed.
5. category = 15 with NUM_CAT = 8; pal_we to addr 9 → RGB 000; no palette entry changes (read back via categories 0–7).
6. Assert rst for one cycle during streaming and blinking → outputs 0 and blink_phase = 1 the next cycle; palette returns to defaults (category 3 → 000).

Source files
------------

// File: rtl/tile_colour_mapper.sv
// Category-to-RGB stage with a run-time writable palette and per-entry blink attribute.
// Two-stage pipeline: palette lookup, then blink/blanking select; one pixel per clock.

module tile_colour_mapper_entry #(
  parameter int               RGB_W   = 12,
  parameter logic [RGB_W-1:0] RST_RGB = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RGB_W-1:0] wrgb,
  input  logic             wblink,
  output logic [RGB_W-1:0] rgb,
  output logic             blink
);
  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic             blink_d, blink_q;

  always_comb begin
    rgb_d   = rgb_q;
    blink_d = blink_q;
    if (we) begin
      rgb_d   = wrgb;
      blink_d = wblink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= RST_RGB;
      blink_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      blink_q <= blink_d;
    end
  end

  assign rgb   = rgb_q;
  assign blink = blink_q;
endmodule

module tile_colour_mapper #(
  parameter int CAT_W        = 4,
  parameter int NUM_CAT      = 16,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 video_on,
  input  logic [CAT_W-1:0]     category,
  input  logic                 pal_we,
  input  logic [CAT_W-1:0]     pal_addr,
  input  logic [3*COLOR_W-1:0] pal_data,
  input  logic                 pal_blink,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 video_on_out,
  output logic                 blink_phase
);
  localparam int RGB_W  = 3 * COLOR_W;
  localparam int STAGES = 2;
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic             blink;
  } pal_ent_t;

  // Palette storage: one register entry per category, reset to the legacy fixed table
  logic [NUM_CAT-1:0]            ent_we;
  logic [NUM_CAT-1:0][RGB_W-1:0] ent_rgb;
  logic [NUM_CAT-1:0]            ent_blink;

  for (genvar g = 0; g < NUM_CAT; g++) begin : g_ent
    localparam logic [RGB_W-1:0] RST_RGB = (g == 1 || g == 2) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
    assign ent_we[g] = pal_we && (pal_addr == CAT_W'(g));
    tile_colour_mapper_entry #(
      .RGB_W  (RGB_W),
      .RST_RGB(RST_RGB)
    ) u_ent (
      .clk   (clk),
      .rst   (rst),
      .we    (ent_we[g]),
      .wrgb  (pal_data),
      .wblink(pal_blink),
      .rgb   (ent_rgb[g]),
      .blink (ent_blink[g])
    );
  end

  // Stage 1: lookup; categories without an implemented entry read as black, non-blinking
  pal_ent_t s1_d, s1_q;
  always_comb begin
    s1_d = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      if (category == CAT_W'(i)) begin
        s1_d.rgb   = ent_rgb[i];
        s1_d.blink = ent_blink[i];
      end
    end
  end

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;
  assign vld_pipe_d = {vld_pipe_q[STAGES-1:1], video_on};

  // Blink phase generator, counts frame ticks
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             phase_d, phase_q;
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stage 2: blanking and blink substitution with the live background entry
  logic [RGB_W-1:0] out_d, out_q;
  always_comb begin
    out_d = '0;
    if (vld_pipe_q[1]) begin
      if (s1_q.blink && !phase_q) out_d = ent_rgb[0];
      else                        out_d = s1_q.rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      out_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      vld_pipe_q <= vld_pipe_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      out_q      <= out_d;
    end
  end

  assign red          = out_q[3*COLOR_W-1:2*COLOR_W];
  assign green        = out_q[2*COLOR_W-1:COLOR_W];
  assign blue         = out_q[COLOR_W-1:0];
  assign video_on_out = vld_pipe_q[STAGES];
  assign blink_phase  = phase_q;
endmodule

// File: tb/tb_tile_colour_mapper.sv
// Scoreboard bench for tile_colour_mapper: directed scenarios followed by random traffic.

module tb_tile_colour_mapper;
  localparam int CAT_W   = 4;
  localparam int NUM_CAT = 8;
  localparam int COLOR_W = 4;
  localparam int BF      = 2;
  localparam int RGB_W   = 3 * COLOR_W;

  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, video_on = 1'b0;
  logic pal_we = 1'b0, pal_blink = 1'b0;
  logic [CAT_W-1:0] category = '0, pal_addr = '0;
  logic [RGB_W-1:0] pal_data = '0;
  logic [COLOR_W-1:0] red, green, blue;
  logic video_on_out, blink_phase;

  tile_colour_mapper #(
    .CAT_W(CAT_W), .NUM_CAT(NUM_CAT), .COLOR_W(COLOR_W), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .video_on(video_on),
    .category(category), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .pal_blink(pal_blink), .red(red), .green(green),
    .blue(blue), .video_on_out(video_on_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RGB_W-1:0] rgb;
    logic             von;
    logic             ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_errors = 0;

  // Reference model: palette array, frame-tick blink state, and the pixel awaiting colour selection
  logic [RGB_W-1:0] m_rgb[16];
  logic             m_blk[16];
  int               m_cnt;
  logic             m_ph;
  logic             p_von, p_blk;
  logic [RGB_W-1:0] p_rgb;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_rgb[i] = (i == 1 || i == 2) ? 12'hFFF : 12'h000;
      m_blk[i] = 1'b0;
    end
    m_cnt = 0; m_ph = 1'b1;
    p_von = 1'b0; p_blk = 1'b0; p_rgb = '0;
  endtask

  task automatic cycle(input logic r, input logic ft, input logic von, input int cat,
                       input logic we, input int addr, input logic [RGB_W-1:0] d, input logic b);
    exp_t e;
    @(negedge clk);
    rst = r; frame_tick = ft; video_on = von; category = CAT_W'(cat);
    pal_we = we; pal_addr = CAT_W'(addr); pal_data = d; pal_blink = b;
    if (r) begin
      m_reset();
      e.rgb = '0; e.von = 1'b0; e.ph = 1'b1;
    end else begin
      e.von = p_von;
      if (!p_von)                 e.rgb = '0;
      else if (p_blk && !m_ph)    e.rgb = m_rgb[0];
      else                        e.rgb = p_rgb;
      p_von = von;
      if (cat < NUM_CAT) begin p_rgb = m_rgb[cat]; p_blk = m_blk[cat]; end
      else begin p_rgb = '0; p_blk = 1'b0; end
      if (we && addr < NUM_CAT) begin m_rgb[addr] = d; m_blk[addr] = b; end
      if (ft) begin
        if (m_cnt == BF - 1) begin m_cnt = 0; m_ph = !m_ph; end
        else m_cnt++;
      end
      e.ph = m_ph;
    end
    exp_q.push_back(e);
  endtask

  task automatic pix(input logic von, input int cat);
    cycle(1'b0, 1'b0, von, cat, 1'b0, 0, '0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({red, green, blue} !== e.rgb || video_on_out !== e.von || blink_phase !== e.ph) begin
          n_errors++;
          $display("FAIL out @%0t: got rgb=%h von=%b ph=%b, want rgb=%h von=%b ph=%b",
                   $time, {red, green, blue}, video_on_out, blink_phase, e.rgb, e.von, e.ph);
        end
      end
    end
  end

  initial begin : stim
    m_reset();
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, '0, 1'b0);
    // fixed-table defaults
    for (int c = 0; c < 4; c++) pix(1'b1, c);
    repeat (2) pix(1'b0, 0);
    // write/lookup collision on entry 3
    cycle(1'b0, 1'b0, 1'b1, 3, 1'b1, 3, 12'hF00, 1'b0);
    pix(1'b1, 3);
    repeat (2) pix(1'b0, 0);
    // video_on blanking
    pix(1'b1, 1); pix(1'b0, 1); pix(1'b1, 1);
    repeat (2) pix(1'b0, 0);
    // out-of-range category and ignored out-of-range write
    cycle(1'b0, 1'b0, 1'b1, 15, 1'b1, 9, 12'h0F0, 1'b1);
    for (int c = 0; c < NUM_CAT; c++) pix(1'b1, c);
    // blinking entry 2 over a background of 00F
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 2, 12'hFFF, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 12'h00F, 1'b0);
    for (int t = 0; t < 6; t++) begin
      repeat (3) pix(1'b1, 2);
      cycle(1'b0, 1'b1, 1'b1, 2, 1'b0, 0, '0, 1'b0);
    end
    // background rewrite while blinking entries are substituted
    cycle(1'b0, 1'b1, 1'b1, 2, 1'b1, 0, 12'h0A0, 1'b0);
    repeat (3) pix(1'b1, 2);
    // reset wins over simultaneous tick and write
    cycle(1'b1, 1'b1, 1'b1, 2, 1'b1, 3, 12'h123, 1'b1);
    repeat (3) pix(1'b1, 3);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) != 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
            RGB_W'($urandom), ($urandom_range(0, 1) == 1));
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
